// File: rtl/rx_parser_pkg.sv
// Shared types, ASCII codes and byte classifiers for the set-point command parser.
// Included by the UART receiver and the parser FSM.
package rx_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EQ,
        TENS,
        ONES,
        DOT,
        TENTHS,
        TERM
    } rx_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    localparam logic [7:0] ASC_S   = 8'h53;
    localparam logic [7:0] ASC_s   = 8'h73;
    localparam logic [7:0] ASC_EQ  = 8'h3D;
    localparam logic [7:0] ASC_DOT = 8'h2E;
    localparam logic [7:0] ASC_0   = 8'h30;
    localparam logic [7:0] ASC_9   = 8'h39;
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_LF  = 8'h0A;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    function automatic logic is_s(input logic [7:0] b);
        return (b == ASC_S) || (b == ASC_s);
    endfunction

endpackage

// File: rtl/rx_parser_if.sv
// Console-side bundle: serial line in, committed BCD set-point and status pulses out.
// master = console/host side, slave = parser.
interface rx_parser_if;
    logic        rx_serial;
    logic [11:0] bcd_setpoint;
    logic        setpoint_valid;
    logic        parse_error;

    modport master (
        output rx_serial,
        input  bcd_setpoint,
        input  setpoint_valid,
        input  parse_error
    );

    modport slave (
        input  rx_serial,
        output bcd_setpoint,
        output setpoint_valid,
        output parse_error
    );
endinterface

// File: rtl/rx_parser_uart_rx.sv
// UART receiver: 2-FF synchroniser, mid-bit start confirmation, LSB-first centre sampling.
// Frames with a low stop bit are dropped silently; rx_valid is a 1-cycle pulse.
module uart_rx
    import rx_parser_pkg::*;
#(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx_serial,
    output logic [NUM_BITS-1:0] rx_byte,
    output logic                rx_valid
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(NUM_BITS + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    uart_state_t         state_q;
    logic                sync1_q, sync2_q, sync3_q;
    logic [CW-1:0]       cnt_q;
    logic [BW-1:0]       bit_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [NUM_BITS-1:0] byte_q;
    logic                valid_q;

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            valid_q <= 1'b0;
            case (state_q)
                U_IDLE: begin
                    // Falling edge only, so a line stuck low after a bad frame cannot retrigger.
                    if (sync3_q && !sync2_q) begin
                        state_q <= U_START;
                        cnt_q   <= '0;
                    end
                end
                U_START: begin
                    if (cnt_q == CW'(HALF - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? U_IDLE : U_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                U_DATA: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[NUM_BITS-1:1]};
                        if (bit_q == BW'(NUM_BITS - 1)) begin
                            state_q <= U_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                U_STOP: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= U_IDLE;
                        if (sync2_q) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= U_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rx_parser.sv
// Parses "S=dd.d<CR|LF>" from the UART console into a 12-bit BCD set-point with valid/error pulses.
// Optional inter-character timeout enabled by defining RX_PARSER_TIMEOUT_EN.
module rx_parser
    import rx_parser_pkg::*;
#(
    parameter int          NUM_BITS       = 8,
    parameter int          CLKS_PER_BIT   = 868,
    parameter logic [11:0] RESET_SETPOINT = 12'h300,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          reset_n,
    rx_parser_if.slave    bus
);

    logic [NUM_BITS-1:0] rx_byte;
    logic                rx_valid;
    logic [7:0]          rx_chr;
    logic [7:0]          diff_d;
    logic [3:0]          digit_d;
    logic                accept_d;
    rx_state_t           next_state_d;
    rx_state_t           fail_state_d;
    logic                tmo_hit;

    rx_state_t   state_q;
    logic [3:0]  tens_q, ones_q, tenths_q;
    logic [11:0] setpoint_q;
    logic        valid_q;
    logic        err_q;

    uart_rx #(
        .NUM_BITS     (NUM_BITS),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_serial (bus.rx_serial),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid)
    );

    assign rx_chr       = 8'(rx_byte);
    assign diff_d       = rx_chr - ASC_0;
    assign digit_d      = diff_d[3:0];
    assign fail_state_d = is_s(rx_chr) ? EQ : IDLE;

    always_comb begin
        accept_d     = 1'b0;
        next_state_d = IDLE;
        case (state_q)
            IDLE:   begin accept_d = is_s(rx_chr);                            next_state_d = EQ;     end
            EQ:     begin accept_d = (rx_chr == ASC_EQ);                      next_state_d = TENS;   end
            TENS:   begin accept_d = is_digit(rx_chr);                        next_state_d = ONES;   end
            ONES:   begin accept_d = is_digit(rx_chr);                        next_state_d = DOT;    end
            DOT:    begin accept_d = (rx_chr == ASC_DOT);                     next_state_d = TENTHS; end
            TENTHS: begin accept_d = is_digit(rx_chr);                        next_state_d = TERM;   end
            TERM:   begin accept_d = (rx_chr == ASC_CR) || (rx_chr == ASC_LF); next_state_d = IDLE;  end
            default: begin accept_d = 1'b0;                                   next_state_d = IDLE;   end
        endcase
    end

`ifdef RX_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q;

    assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || rx_valid || state_q == IDLE) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tens_q     <= '0;
            ones_q     <= '0;
            tenths_q   <= '0;
            setpoint_q <= RESET_SETPOINT;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (rx_valid) begin
                if (accept_d) begin
                    state_q <= next_state_d;
                    case (state_q)
                        TENS:   tens_q   <= digit_d;
                        ONES:   ones_q   <= digit_d;
                        TENTHS: tenths_q <= digit_d;
                        TERM: begin
                            setpoint_q <= {tens_q, ones_q, tenths_q};
                            valid_q    <= 1'b1;
                        end
                        default: ;
                    endcase
                end else if (state_q != IDLE) begin
                    // An 'S' that breaks a command restarts parsing instead of being lost.
                    state_q  <= fail_state_d;
                    err_q    <= 1'b1;
                    tens_q   <= '0;
                    ones_q   <= '0;
                    tenths_q <= '0;
                end
            end else if (tmo_hit) begin
                state_q  <= IDLE;
                err_q    <= 1'b1;
                tens_q   <= '0;
                ones_q   <= '0;
                tenths_q <= '0;
            end
        end
    end

    assign bus.bcd_setpoint   = setpoint_q;
    assign bus.setpoint_valid = valid_q;
    assign bus.parse_error    = err_q;

endmodule

// File: tb/tb_rx_parser.sv
// Bench for rx_parser: bit-accurate UART driver, table of commands, event scoreboard.
module tb_rx_parser;
    import rx_parser_pkg::*;

    localparam int CPB = 16;

    typedef struct {
        string       txt;
        string       ev;
        logic [11:0] sp;
    } vec_t;

    typedef struct {
        byte         kind;
        logic [11:0] sp;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   stop_cyc = 0;
    int   last_v_cyc = 0;
    bit   mon_en = 1'b0;
    ev_t  exp_q[$];
    vec_t vecs[10];

    rx_parser_if bus ();

    rx_parser #(
        .NUM_BITS       (8),
        .CLKS_PER_BIT   (CPB),
        .RESET_SETPOINT (12'h300),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every flag pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.setpoint_valid === 1'b1 && bus.parse_error === 1'b1)
                check("both_flags", 32'd1, 32'd0);
            if (bus.setpoint_valid === 1'b1 || bus.parse_error === 1'b1) begin
                byte got;
                ev_t e;
                got = (bus.setpoint_valid === 1'b1) ? "V" : "E";
                if (got == "V") last_v_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(got), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(got), 32'(e.kind));
                    if (got == "V") check("commit_value", 32'(bus.bcd_setpoint), 32'(e.sp));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1 bus.rx_serial = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 bus.rx_serial = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 bus.rx_serial = stop_bit;
        stop_cyc = cyc;
        repeat (CPB) @(posedge clk);
        #1 bus.rx_serial = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic push_events(input string ev, input logic [11:0] sp);
        for (int i = 0; i < ev.len(); i++) begin
            ev_t e;
            e.kind = ev[i];
            e.sp   = sp;
            exp_q.push_back(e);
        end
    endtask

    task automatic settle_and_check(input string name, input logic [11:0] sp);
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_setpoint"}, 32'(bus.bcd_setpoint), 32'(sp));
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{"S=23.5\015",         "V",  12'h235};
        vecs[1] = '{"s=07.0\n\015\n",     "V",  12'h070};
        vecs[2] = '{"S=2x.5\015",         "E",  12'h070};
        vecs[3] = '{"S=1S=45.0\015",      "EV", 12'h450};
        vecs[4] = '{"S=99.9\015",         "V",  12'h999};
        vecs[5] = '{"S=99.9\n",           "V",  12'h999};
        vecs[6] = '{"xyz\015",            "",   12'h999};
        vecs[7] = '{"S=0.5\015",          "E",  12'h999};
        vecs[8] = '{"S=12.34\015",        "E",  12'h999};
        vecs[9] = '{"s=80.1\015",         "V",  12'h801};

        bus.rx_serial = 1'b1;
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_setpoint", 32'(bus.bcd_setpoint), 32'h300);
        check("reset_valid", 32'(bus.setpoint_valid), 32'd0);
        check("reset_error", 32'(bus.parse_error), 32'd0);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            push_events(vecs[i].ev, vecs[i].sp);
            send_str(vecs[i].txt);
            settle_and_check($sformatf("vec%0d", i), vecs[i].sp);
            if (i == 0) begin
                check("commit_latency_min", 32'(last_v_cyc - stop_cyc >= CPB / 2), 32'd1);
                check("commit_latency_max", 32'(last_v_cyc - stop_cyc <= CPB / 2 + 8), 32'd1);
            end
        end

        // '=' arrives with a bad stop bit and is dropped, so '1' errors in EQ.
        push_events("E", 12'h801);
        send_byte(ASC_S, 1'b1);
        send_byte(ASC_EQ, 1'b0);
        send_str("12.3\015");
        settle_and_check("bad_stop", 12'h801);

        // Reset in the middle of a command discards it without any pulse.
        send_str("S=9");
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midreset_valid", 32'(bus.setpoint_valid), 32'd0);
        check("midreset_error", 32'(bus.parse_error), 32'd0);
        #1 reset_n = 1'b1;
        send_str("\015");
        settle_and_check("midreset", 12'h300);

`ifdef RX_PARSER_TIMEOUT_EN
        push_events("E", 12'h300);
        send_str("S=4");
        repeat (600) @(posedge clk);
        settle_and_check("timeout_gap", 12'h300);
        push_events("V", 12'h412);
        send_str("S=41.2\015");
        settle_and_check("after_timeout", 12'h412);
`else
        send_str("S=4");
        repeat (600) @(posedge clk);
        settle_and_check("no_timeout_gap", 12'h300);
        push_events("V", 12'h412);
        send_str("1.2\015");
        settle_and_check("resume_after_gap", 12'h412);
`endif

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
